alu_sequencer: RTL and testbench

Command-driven controller that sequences the 4-bit-operand / 8-bit-result ALU (alublock) around an 8-bit accumulator. It issues single-cycle ALU operations with A = command operand and B = acc[3:0], and writes the ALU result back to acc. It also runs a 4-step shift-add multiply built from repeated ALU f=2 adds. It sits between switch/key input logic and the ALU; the ALU itself stays external.

---
 rtl/alu_sequencer.sv | 157 +++++++++++++++
 tb/tb_alu_sequencer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// alu_sequencer
//
// Command-driven controller that sequences an external 4-bit-operand /
// 8-bit-result ALU around an 8-bit accumulator.
//
// Single ALU commands run for one cycle. They use A = captured operand and
// B = acc[3:0], and the ALU result is written back to acc. CLEAR zeroes acc
// directly without going through the ALU. MUL multiplies the captured operand
// by acc[3:0] with a 4-step shift-add loop, using the ALU's add function.
//
// Ports:
//   clk        in   1  rising-edge clock
//   resetn     in   1  synchronous reset, active-low
//   start      in   1  command strobe, sampled only in IDLE
//   op         in   3  0-5 single ALU function, 6 MUL, 7 CLEAR
//   a_in       in   4  command operand, captured when start is accepted
//   alu_a      out  4  ALU operand A
//   alu_b      out  4  ALU operand B
//   alu_f      out  3  ALU function select
//   alu_result in   8  ALU combinational result
//   acc        out  8  accumulator (registered)
//   acc_zero   out  1  acc == 0
//   busy       out  1  high in EXEC and MUL
//   done       out  1  one-cycle completion pulse (DONE state)
module alu_sequencer #(
    parameter int MUL_STEPS = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic [2:0] op,
    input  logic [3:0] a_in,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_f,
    input  logic [7:0] alu_result,
    output logic [7:0] acc,
    output logic       acc_zero,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] OP_MUL   = 3'd6;
    localparam logic [2:0] OP_CLEAR = 3'd7;
    localparam logic [2:0] F_ADD    = 3'b010;
    localparam logic [2:0] F_IDLE   = 3'b111;
    localparam logic [1:0] CNT_LAST = 2'(MUL_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t     state, state_nxt;
    logic [3:0] opa;
    logic [2:0] opr;
    logic [1:0] cnt;
    logic [3:0] mq;   // multiplier bits still to consume; product low bits shift in from the top
    logic [3:0] ph;   // running partial product, high nibble

    // State register and datapath registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state <= IDLE;
            acc   <= 8'h00;
            opa   <= 4'h0;
            opr   <= 3'h0;
            cnt   <= 2'd0;
            mq    <= 4'h0;
            ph    <= 4'h0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        opa <= a_in;
                        opr <= op;
                        if (op == OP_MUL) begin
                            mq  <= acc[3:0];
                            ph  <= 4'h0;
                            cnt <= 2'd0;
                        end
                    end
                end
                EXEC: begin
                    if (opr == OP_CLEAR)
                        acc <= 8'h00;
                    else if (opr != OP_MUL)
                        acc <= alu_result;
                end
                MUL: begin
                    // alu_result[4:0] is ph + (mq[0] ? opa : 0); bit 0 drops
                    // out as a finished product bit and the rest shifts down.
                    ph  <= alu_result[4:1];
                    mq  <= {alu_result[0], mq[3:1]};
                    cnt <= cnt + 2'd1;
                    if (cnt == CNT_LAST)
                        acc <= {alu_result[4:1], alu_result[0], mq[3:1]};
                end
                default: begin
                end
            endcase
        end
    end

    // Next-state and output decode
    always_comb begin
        state_nxt = state;
        alu_a     = 4'h0;
        alu_b     = 4'h0;
        alu_f     = F_IDLE;
        busy      = 1'b0;
        done      = 1'b0;

        case (state)
            IDLE: begin
                if (start)
                    state_nxt = (op == OP_MUL) ? MUL : EXEC;
            end
            EXEC: begin
                alu_a     = opa;
                alu_b     = acc[3:0];
                alu_f     = opr;
                busy      = 1'b1;
                state_nxt = DONE;
            end
            MUL: begin
                alu_a = ph;
                alu_b = mq[0] ? opa : 4'h0;
                alu_f = F_ADD;
                busy  = 1'b1;
                if (cnt == CNT_LAST)
                    state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        // While reset is held the block must look idle to the ALU and the
        // user, regardless of the state it is about to leave.
        if (!resetn) begin
            alu_a = 4'h0;
            alu_b = 4'h0;
            alu_f = F_IDLE;
            busy  = 1'b0;
            done  = 1'b0;
        end
    end

    assign acc_zero = (acc == 8'h00);

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;

    logic       clk;
    logic       resetn;
    logic       start;
    logic [2:0] op;
    logic [3:0] a_in;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [2:0] alu_f;
    logic [7:0] alu_result;
    logic [7:0] acc;
    logic       acc_zero;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    alu_sequencer #(.MUL_STEPS(4)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .op         (op),
        .a_in       (a_in),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_f      (alu_f),
        .alu_result (alu_result),
        .acc        (acc),
        .acc_zero   (acc_zero),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for the external ALU.
    always_comb begin
        case (alu_f)
            3'd0:    alu_result = {4'h0, alu_a} + 8'd1;
            3'd1:    alu_result = {4'h0, alu_a} + {4'h0, alu_b};
            3'd2:    alu_result = {4'h0, alu_a} + {4'h0, alu_b};
            3'd3:    alu_result = {alu_a | alu_b, alu_a ^ alu_b};
            3'd4:    alu_result = {7'h00, |{alu_a, alu_b}};
            3'd5:    alu_result = {alu_a, alu_b};
            default: alu_result = 8'h00;
        endcase
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents a command for one edge; returns in the first EXEC/MUL cycle.
    task automatic cmd(input logic [2:0] o, input logic [3:0] a);
        start = 1'b1;
        op    = o;
        a_in  = a;
        tick();
        start = 1'b0;
        op    = 3'd0;
        a_in  = 4'h0;
    endtask

    task automatic run_single(input string tag, input logic [2:0] o, input logic [3:0] a,
                              input logic [7:0] exp);
        cmd(o, a);
        tick();
        chk({tag, "_acc"}, acc, exp);
        chk({tag, "_done"}, {7'h0, done}, 8'h01);
        tick();
    endtask

    initial begin
        resetn = 1'b0;
        start  = 1'b1;
        op     = 3'd1;
        a_in   = 4'h5;

        // 1: reset, with start held high
        tick();
        chk("rst_acc", acc, 8'h00);
        chk("rst_acc_zero", {7'h0, acc_zero}, 8'h01);
        chk("rst_busy", {7'h0, busy}, 8'h00);
        chk("rst_done", {7'h0, done}, 8'h00);
        chk("rst_alu_f", {5'h0, alu_f}, 8'h07);
        tick();
        chk("rst_hold_busy", {7'h0, busy}, 8'h00);
        chk("rst_hold_alu_a", {4'h0, alu_a}, 8'h00);
        start  = 1'b0;
        resetn = 1'b1;
        tick();
        chk("idle_busy", {7'h0, busy}, 8'h00);

        // 2: single op f=1, acc=0, a=5
        cmd(3'd1, 4'h5);
        chk("ex_alu_a", {4'h0, alu_a}, 8'h05);
        chk("ex_alu_b", {4'h0, alu_b}, 8'h00);
        chk("ex_alu_f", {5'h0, alu_f}, 8'h01);
        chk("ex_busy", {7'h0, busy}, 8'h01);
        chk("ex_done", {7'h0, done}, 8'h00);
        chk("ex_acc_hold", acc, 8'h00);
        tick();
        chk("ex_acc", acc, 8'h05);
        chk("ex_done_hi", {7'h0, done}, 8'h01);
        chk("ex_busy_lo", {7'h0, busy}, 8'h00);
        chk("ex_acc_zero", {7'h0, acc_zero}, 8'h00);
        tick();
        chk("ex_done_lo", {7'h0, done}, 8'h00);

        // 3: f=3 then f=5
        run_single("clr1", 3'd7, 4'h0, 8'h00);
        run_single("ld0c", 3'd1, 4'hC, 8'h0C);
        run_single("f3", 3'd3, 4'hA, 8'hE6);
        run_single("f5", 3'd5, 4'h3, 8'h36);

        // 4: multiply 0xF * 0x5
        run_single("clr2", 3'd7, 4'h0, 8'h00);
        run_single("ld05", 3'd1, 4'h5, 8'h05);
        cmd(3'd6, 4'hF);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("mul_busy%0d", i), {7'h0, busy}, 8'h01);
            chk($sformatf("mul_f%0d", i), {5'h0, alu_f}, 8'h02);
            chk($sformatf("mul_b%0d", i), {4'h0, alu_b}, (i % 2 == 0) ? 8'h0F : 8'h00);
            chk($sformatf("mul_acc%0d", i), acc, 8'h05);
            chk($sformatf("mul_done%0d", i), {7'h0, done}, 8'h00);
            tick();
        end
        chk("mul_acc", acc, 8'h4B);
        chk("mul_done", {7'h0, done}, 8'h01);
        chk("mul_busy_lo", {7'h0, busy}, 8'h00);
        tick();
        chk("mul_done_lo", {7'h0, done}, 8'h00);

        // 15 x 15
        run_single("clr3", 3'd7, 4'h0, 8'h00);
        run_single("ld0f", 3'd1, 4'hF, 8'h0F);
        cmd(3'd6, 4'hF);
        tick(); tick(); tick(); tick();
        chk("mul_ff", acc, 8'hE1);
        chk("mul_ff_done", {7'h0, done}, 8'h01);
        tick();

        // 0 x 7
        run_single("clr4", 3'd7, 4'h0, 8'h00);
        cmd(3'd6, 4'h7);
        tick(); tick(); tick(); tick();
        chk("mul_07", acc, 8'h00);
        chk("mul_07_done", {7'h0, done}, 8'h01);
        tick();

        // 5: start during MUL step 2 is ignored
        run_single("ld05b", 3'd1, 4'h5, 8'h05);
        cmd(3'd6, 4'hF);
        tick();
        start = 1'b1;
        op    = 3'd7;
        tick();
        start = 1'b0;
        op    = 3'd0;
        chk("ign_busy", {7'h0, busy}, 8'h01);
        tick(); tick();
        chk("ign_acc", acc, 8'h4B);
        chk("ign_done", {7'h0, done}, 8'h01);
        tick();
        chk("ign_idle", {7'h0, busy}, 8'h00);
        run_single("clr5", 3'd7, 4'h0, 8'h00);
        chk("clr_zero", {7'h0, acc_zero}, 8'h01);

        // 6: reset at MUL step 2
        run_single("ld05c", 3'd1, 4'h5, 8'h05);
        cmd(3'd6, 4'hF);
        tick();
        resetn = 1'b0;
        #1;
        chk("abort_busy_held", {7'h0, busy}, 8'h00);
        chk("abort_f_held", {5'h0, alu_f}, 8'h07);
        tick();
        resetn = 1'b1;
        chk("abort_acc", acc, 8'h00);
        chk("abort_done", {7'h0, done}, 8'h00);
        #1;
        chk("abort_busy", {7'h0, busy}, 8'h00);
        tick();
        chk("abort_no_done", {7'h0, done}, 8'h00);
        chk("abort_idle", {7'h0, busy}, 8'h00);
        tick();
        chk("abort_no_done2", {7'h0, done}, 8'h00);
        run_single("post", 3'd1, 4'h2, 8'h02);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
